// File: rtl/reg_wb_queue_if.sv
// Register-file write-back bus: pipeline and MDU producers in, write port and scoreboard out.
interface reg_wb_queue_if #(
  parameter int unsigned PTR_W = 2
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          mdu_valid;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          mdu_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          reg_write;
  logic [DW-1:0] busy;
  logic [PTR_W:0] count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, rd_addr, rd_data, reg_write, busy, count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, rd_addr, rd_data, reg_write, busy, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back driver merging MEM/WB writes and queued MDU results onto one register-file port.
// Optional feature: define WBQ_BYPASS_EN to send MDU results straight out when the queue is idle.
module reg_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_wb_queue_if.slave  bus
);
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t            mem_q [DEPTH];
  wb_entry_t            mem_n [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_n;
  logic [DEPTH-1:0]     live_q, live_n;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]     count_q, count_n;
  logic                 ready_q, ready_n;
  logic [NREG-1:0]      busy_q, busy_n;
  logic [AW-1:0]        rd_addr_q, rd_addr_n;
  logic [DW-1:0]        rd_data_q, rd_data_n;
  logic                 reg_write_q, reg_write_n;

  logic pipe_req, accept, head_valid, head_live, bypass, push, pop;

  // Next-state: arbitration, cancellation, FIFO update and scoreboard
  always_comb begin
    mem_n       = mem_q;
    valid_n     = valid_q;
    live_n      = live_q;
    wr_ptr_n    = wr_ptr_q;
    rd_ptr_n    = rd_ptr_q;
    rd_addr_n   = rd_addr_q;
    rd_data_n   = rd_data_q;
    reg_write_n = 1'b0;
    busy_n      = '0;

    pipe_req   = bus.pipe_we && (bus.pipe_addr != '0);
    accept     = bus.mdu_valid && ready_q;
    head_valid = valid_q[rd_ptr_q];
    head_live  = head_valid && live_q[rd_ptr_q];
    bypass     = 1'b0;
`ifdef WBQ_BYPASS_EN
    bypass     = accept && (count_q == '0) && !pipe_req && (bus.mdu_addr != '0);
`else
    bypass     = 1'b0;
`endif
    push = accept && (bus.mdu_addr != '0) && !bypass;
    pop  = !pipe_req && head_valid;

    // The pipeline write is younger than every queued result to the same register
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_req && valid_q[i] && (mem_q[i].addr == bus.pipe_addr)) begin
        live_n[i] = 1'b0;
      end
    end

    if (pop) begin
      valid_n[rd_ptr_q] = 1'b0;
      live_n[rd_ptr_q]  = 1'b0;
      rd_ptr_n          = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      mem_n[wr_ptr_q].addr = bus.mdu_addr;
      mem_n[wr_ptr_q].data = bus.mdu_data;
      valid_n[wr_ptr_q]    = 1'b1;
      live_n[wr_ptr_q]     = 1'b1;
      wr_ptr_n             = wr_ptr_q + PTR_W'(1);
    end

    count_n = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_n = (count_n < CNT_W'(DEPTH));

    // A cancelled head still consumes the slot but issues nothing
    if (pipe_req) begin
      reg_write_n = 1'b1;
      rd_addr_n   = bus.pipe_addr;
      rd_data_n   = bus.pipe_data;
    end else if (head_live) begin
      reg_write_n = 1'b1;
      rd_addr_n   = mem_q[rd_ptr_q].addr;
      rd_data_n   = mem_q[rd_ptr_q].data;
    end else if (bypass) begin
      reg_write_n = 1'b1;
      rd_addr_n   = bus.mdu_addr;
      rd_data_n   = bus.mdu_data;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_n[i] && live_n[i]) begin
        busy_n[mem_n[i].addr] = 1'b1;
      end
    end
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q     <= '0;
      live_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      mem_q       <= mem_n;
      valid_q     <= valid_n;
      live_q      <= live_n;
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      count_q     <= count_n;
      ready_q     <= ready_n;
      busy_q      <= busy_n;
      rd_addr_q   <= rd_addr_n;
      rd_data_q   <= rd_data_n;
      reg_write_q <= reg_write_n;
    end
  end

  assign bus.mdu_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.reg_write = reg_write_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, priority, FIFO drain, WAW cancellation, register 0.
module tb_reg_wb_queue;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_wb_queue_if #(.PTR_W(2)) bus ();

  reg_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pipe_we   = 1'b0;
    bus.pipe_addr = '0;
    bus.pipe_data = '0;
    bus.mdu_valid = 1'b0;
    bus.mdu_addr  = '0;
    bus.mdu_data  = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_rd_addr",   32'(bus.rd_addr),   32'd0);
    chk("rst_rd_data",   bus.rd_data,        32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_busy",      bus.busy,           32'd0);
    chk("rst_ready",     32'(bus.mdu_ready), 32'd1);
    rst_n = 1'b1;

    // Test 1: queue three results behind pipeline writes, then reset mid-operation
    for (int k = 0; k < 3; k++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_addr = 5'd1;
      bus.pipe_data = 32'h11;
      bus.mdu_valid = 1'b1;
      bus.mdu_addr  = 5'(20 + k);
      bus.mdu_data  = 32'hA0 + 32'(k);
      cyc();
      chk("t1_pipe_addr", 32'(bus.rd_addr), 32'd1);
    end
    chk("t1_count", 32'(bus.count), 32'd3);
    chk("t1_busy",  bus.busy,       32'h0070_0000);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t1_async_count", 32'(bus.count),     32'd0);
    chk("t1_async_busy",  bus.busy,           32'd0);
    chk("t1_async_rw",    32'(bus.reg_write), 32'd0);
    chk("t1_async_ready", 32'(bus.mdu_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t1_no_stale_rw",    32'(bus.reg_write), 32'd0);
    chk("t1_no_stale_count", 32'(bus.count),     32'd0);
    cyc();
    chk("t1_no_stale_rw2",   32'(bus.reg_write), 32'd0);

    // Test 2: pipeline write appears one cycle later; outputs hold when idle
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd5;
    bus.pipe_data = 32'h0000_1234;
    cyc();
    chk("t2_rw",   32'(bus.reg_write), 32'd1);
    chk("t2_addr", 32'(bus.rd_addr),   32'd5);
    chk("t2_data", bus.rd_data,        32'h0000_1234);
    idle();
    cyc();
    chk("t2_idle_rw",   32'(bus.reg_write), 32'd0);
    chk("t2_hold_addr", 32'(bus.rd_addr),   32'd5);
    chk("t2_hold_data", bus.rd_data,        32'h0000_1234);

    // Test 3: lone MDU result
    bus.mdu_valid = 1'b1;
    bus.mdu_addr  = 5'd8;
    bus.mdu_data  = 32'hCAFE_F00D;
    cyc();
    idle();
`ifdef WBQ_BYPASS_EN
    chk("t3_byp_rw",   32'(bus.reg_write), 32'd1);
    chk("t3_byp_addr", 32'(bus.rd_addr),   32'd8);
    chk("t3_byp_data", bus.rd_data,        32'hCAFE_F00D);
    chk("t3_byp_busy", bus.busy,           32'd0);
    cyc();
    chk("t3_byp_rw2",  32'(bus.reg_write), 32'd0);
    chk("t3_byp_busy2", bus.busy,          32'd0);
`else
    chk("t3_busy_set", bus.busy,           32'h0000_0100);
    chk("t3_rw_n1",    32'(bus.reg_write), 32'd0);
    chk("t3_count_n1", 32'(bus.count),     32'd1);
    cyc();
    chk("t3_rw_n2",    32'(bus.reg_write), 32'd1);
    chk("t3_addr_n2",  32'(bus.rd_addr),   32'd8);
    chk("t3_data_n2",  bus.rd_data,        32'hCAFE_F00D);
    chk("t3_busy_clr", bus.busy,           32'd0);
    chk("t3_count_n2", 32'(bus.count),     32'd0);
`endif

    // Test 4: pipeline writes every cycle while the MDU fills the queue
    for (int k = 0; k < 6; k++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_addr = 5'(k + 1);
      bus.pipe_data = 32'hA000 + 32'(k);
      bus.mdu_valid = 1'b1;
      bus.mdu_addr  = 5'(10 + ((k < 4) ? k : 4));
      bus.mdu_data  = 32'h1000 + 32'(10 + ((k < 4) ? k : 4));
      cyc();
      chk("t4_pipe_rw",   32'(bus.reg_write), 32'd1);
      chk("t4_pipe_addr", 32'(bus.rd_addr),   32'(k + 1));
      chk("t4_pipe_data", bus.rd_data,        32'hA000 + 32'(k));
      chk("t4_ready",     32'(bus.mdu_ready), (k < 3) ? 32'd1 : 32'd0);
      chk("t4_count",     32'(bus.count),     (k < 3) ? 32'(k + 1) : 32'd4);
    end
    chk("t4_busy_full", bus.busy, 32'h0000_3C00);
    bus.pipe_we = 1'b0;
    cyc();
    chk("t4_drain10_addr", 32'(bus.rd_addr),   32'd10);
    chk("t4_drain10_rw",   32'(bus.reg_write), 32'd1);
    chk("t4_drain10_cnt",  32'(bus.count),     32'd3);
    chk("t4_refill_ready", 32'(bus.mdu_ready), 32'd1);
    cyc();
    chk("t4_drain11_addr", 32'(bus.rd_addr),   32'd11);
    chk("t4_pushpop_cnt",  32'(bus.count),     32'd3);
    idle();
    for (int j = 12; j <= 14; j++) begin
      cyc();
      chk("t4_drain_rw",   32'(bus.reg_write), 32'd1);
      chk("t4_drain_addr", 32'(bus.rd_addr),   32'(j));
      chk("t4_drain_data", bus.rd_data,        32'h1000 + 32'(j));
    end
    cyc();
    chk("t4_empty_rw",    32'(bus.reg_write), 32'd0);
    chk("t4_empty_count", 32'(bus.count),     32'd0);
    chk("t4_empty_busy",  bus.busy,           32'd0);

    // Test 5: younger pipeline write cancels the queued r9 result
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd1;
    bus.pipe_data = 32'h55;
    bus.mdu_valid = 1'b1;
    bus.mdu_addr  = 5'd9;
    bus.mdu_data  = 32'h1;
    cyc();
    chk("t5_busy9_set", bus.busy,       32'h0000_0200);
    chk("t5_count1",    32'(bus.count), 32'd1);
    bus.mdu_valid = 1'b0;
    bus.pipe_addr = 5'd9;
    bus.pipe_data = 32'h2;
    cyc();
    chk("t5_pipe_rw",   32'(bus.reg_write), 32'd1);
    chk("t5_pipe_addr", 32'(bus.rd_addr),   32'd9);
    chk("t5_pipe_data", bus.rd_data,        32'h2);
    chk("t5_busy9_clr", bus.busy,           32'd0);
    chk("t5_cnt_kept",  32'(bus.count),     32'd1);
    idle();
    cyc();
    chk("t5_cancel_rw",    32'(bus.reg_write), 32'd0);
    chk("t5_cancel_count", 32'(bus.count),     32'd0);
    chk("t5_cancel_data",  bus.rd_data,        32'h2);
    cyc();
    chk("t5_after_rw",     32'(bus.reg_write), 32'd0);

    // Test 6: pipeline write to r0 frees the slot; MDU result to r0 is swallowed
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd2;
    bus.pipe_data = 32'h22;
    bus.mdu_valid = 1'b1;
    bus.mdu_addr  = 5'd3;
    bus.mdu_data  = 32'h333;
    cyc();
    chk("t6_count1", 32'(bus.count), 32'd1);
    chk("t6_busy3",  bus.busy,       32'h0000_0008);
    bus.mdu_valid = 1'b0;
    bus.pipe_addr = 5'd0;
    bus.pipe_data = 32'hBAD0_BAD0;
    cyc();
    chk("t6_r0_rw",    32'(bus.reg_write), 32'd1);
    chk("t6_r0_addr",  32'(bus.rd_addr),   32'd3);
    chk("t6_r0_data",  bus.rd_data,        32'h333);
    chk("t6_r0_count", 32'(bus.count),     32'd0);
    idle();
    bus.mdu_valid = 1'b1;
    bus.mdu_addr  = 5'd0;
    bus.mdu_data  = 32'hDEAD_BEEF;
    cyc();
    chk("t6_mdu0_count", 32'(bus.count),     32'd0);
    chk("t6_mdu0_rw",    32'(bus.reg_write), 32'd0);
    chk("t6_mdu0_busy",  bus.busy,           32'd0);
    chk("t6_mdu0_ready", 32'(bus.mdu_ready), 32'd1);
    idle();
    cyc();
    chk("t6_final_rw",   32'(bus.reg_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
